mvm_column_accumulator: RTL and testbench

//  Matrix-vector multiply engine directly downstream of the weight RAM.

---
 rtl/mvm_column_accumulator.sv | 171 +++++++++++++++++
 tb/tb_mvm_column_accumulator.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_column_accumulator.sv
// mvm_column_accumulator
// Matrix-vector multiply engine sitting directly behind the weight RAM.
// On start it latches the input vector, then walks the weight RAM column
// address 0..NCOL-1. Each returned column (NROW words) is multiplied by the
// matching latched vector element and accumulated into NROW wide
// accumulators. After the last column the accumulators are rescaled back to
// the Q-format of the inputs and presented on dotOutput with a one-cycle
// dataReady pulse.
//
// Timing: the weight RAM registers weightRow on the falling edge from
// weightAddress, so the column addressed at posedge k is consumed at
// posedge k+1. A start sampled at posedge S produces dataReady high after
// posedge S+NCOL+1.
//
// Build option:
//   ACC_SATURATE_EN  defined   -> rescaled result clamps to the BITWIDTH range
//                    undefined -> rescaled result keeps its low BITWIDTH bits
module mvm_column_accumulator #(
  parameter int NROW          = 16,
  parameter int NCOL          = 16,
  parameter int BITWIDTH      = 18,
  parameter int FRAC          = 11,
  parameter int ADDR_BITWIDTH = 4,
  parameter int ACC_WIDTH     = 2 * BITWIDTH + ADDR_BITWIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NCOL*BITWIDTH-1:0]     vecInput,
  input  logic [NROW*BITWIDTH-1:0]     weightRow,
  output logic [ADDR_BITWIDTH-1:0]     weightAddress,
  output logic                         busy,
  output logic                         dataReady,
  output logic [NROW*BITWIDTH-1:0]     dotOutput
);

  // Controller states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WRAP = 2'd2;

  // Index of the final column; the address stops here rather than wrapping.
  localparam logic [ADDR_BITWIDTH-1:0] COL_LAST = ADDR_BITWIDTH'(NCOL - 1);

  // Width of the sign extension from a full product to the accumulator.
  localparam int PROD_WIDTH = 2 * BITWIDTH;
  localparam int EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;

`ifdef ACC_SATURATE_EN
  // Representable range of a BITWIDTH-bit signed result, at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
`endif

  logic [1:0]                 state;
  logic [ADDR_BITWIDTH-1:0]   col_cnt;
  logic [NCOL*BITWIDTH-1:0]   vec_latched;
  logic signed [BITWIDTH-1:0] cur_elem;
  logic                       start_accept;
  logic                       acc_en;
  logic                       out_en;

  // Drop the fractional bits of an accumulator (arithmetic shift, rounds
  // toward -inf) and narrow it to the output word.
  function automatic logic [BITWIDTH-1:0] rescale(
    input logic signed [ACC_WIDTH-1:0] acc_val
  );
`ifdef ACC_SATURATE_EN
    logic signed [ACC_WIDTH-1:0] shifted;
    shifted = acc_val >>> FRAC;
    if (shifted > SAT_MAX) begin
      return SAT_MAX[BITWIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      return SAT_MIN[BITWIDTH-1:0];
    end
    return shifted[BITWIDTH-1:0];
`else
    return BITWIDTH'(acc_val >>> FRAC);
`endif
  endfunction

  // A new product is only accepted from IDLE; start while busy is dropped.
  assign start_accept = (state == ST_IDLE) && start;
  assign acc_en       = (state == ST_RUN);
  assign out_en       = (state == ST_WRAP);
  assign busy         = (state == ST_RUN) || (state == ST_WRAP);

  // Vector element matching the column that arrives on weightRow this cycle.
  assign cur_elem = vec_latched[int'(col_cnt)*BITWIDTH +: BITWIDTH];

  // Sequence the column walk: latch the vector, step the address, pulse ready.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    if (!reset) begin
      state         <= ST_IDLE;
      col_cnt       <= '0;
      weightAddress <= '0;
      vec_latched   <= '0;
      dataReady     <= 1'b0;
    end else begin
      dataReady <= 1'b0;
      case (state)
        ST_IDLE: begin
          weightAddress <= '0;
          if (start) begin
            vec_latched <= vecInput;
            col_cnt     <= '0;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          col_cnt <= col_cnt + ADDR_BITWIDTH'(1);
          if (col_cnt == COL_LAST) begin
            weightAddress <= COL_LAST;
            state         <= ST_WRAP;
          end else begin
            weightAddress <= col_cnt + ADDR_BITWIDTH'(1);
          end
        end
        ST_WRAP: begin
          weightAddress <= '0;
          dataReady     <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          weightAddress <= '0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  // One multiply-accumulate lane and output register per row.
  for (genvar g = 0; g < NROW; g++) begin : g_row
    logic signed [BITWIDTH-1:0]   weight;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [BITWIDTH-1:0]          dot;

    assign weight  = weightRow[g*BITWIDTH +: BITWIDTH];
    // Operands are sign-extended to the product width so the multiply is a
    // full signed BITWIDTH x BITWIDTH product.
    assign product = $signed({{BITWIDTH{weight[BITWIDTH-1]}}, weight}) *
                     $signed({{BITWIDTH{cur_elem[BITWIDTH-1]}}, cur_elem});

    // Clear on accepted start, accumulate during RUN, publish during WRAP.
    always_ff @(posedge clk or negedge reset) begin
      // NOTE: the accumulators and result words are reset explicitly because
      // dotOutput must read zero straight out of reset and after an abort.
      if (!reset) begin
        acc <= '0;
        dot <= '0;
      end else begin
        if (start_accept) begin
          acc <= '0;
        end else if (acc_en) begin
          acc <= acc + {{EXT_WIDTH{product[PROD_WIDTH-1]}}, product};
        end
        if (out_en) begin
          dot <= rescale(acc);
        end
      end
    end

    assign dotOutput[g*BITWIDTH +: BITWIDTH] = dot;
  end

endmodule

// File: tb/tb_mvm_column_accumulator.sv
// tb_mvm_column_accumulator
// Self-checking bench for mvm_column_accumulator with a behavioural weight
// RAM (registered on the falling edge). Table-driven runs push their expected
// result vector to a scoreboard queue; a monitor pops and compares whenever
// dataReady pulses. Hand-written sequences cover ignored starts, back-to-back
// starts and a reset abort. Honours ACC_SATURATE_EN like the design.
`timescale 1ns/1ps
module tb_mvm_column_accumulator;

  localparam int NROW = 16;
  localparam int NCOL = 16;
  localparam int BW   = 18;
  localparam int FRAC = 11;
  localparam int AW   = 4;
  localparam int VW   = NCOL * BW;
  localparam int OW   = NROW * BW;
  localparam longint RMAX = (longint'(1) << (BW - 1)) - 1;
  localparam longint RMIN = -(longint'(1) << (BW - 1));

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [VW-1:0] vecInput = '0;
  logic [OW-1:0] weightRow = '0;
  logic [AW-1:0] weightAddress;
  logic          busy;
  logic          dataReady;
  logic [OW-1:0] dotOutput;

  int            ram_mode = 0;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            ready_pulses = 0;
  int            runs_expected = 0;
  int            last_ready_cyc = -1;
  int            prev_ready_cyc = -1;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] last_exp = '0;

  typedef struct {
    logic [VW-1:0] vec;
    int            mode;
    bit            use_const;
    int            row_val;
  } vector_t;

  vector_t tbl[10];

  mvm_column_accumulator #(
    .NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW), .FRAC(FRAC), .ADDR_BITWIDTH(AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .vecInput      (vecInput),
    .weightRow     (weightRow),
    .weightAddress (weightAddress),
    .busy          (busy),
    .dataReady     (dataReady),
    .dotOutput     (dotOutput)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Weight contents: mode 0 is weight[i][j] = j<<FRAC, mode 1 varies by row.
  function automatic logic signed [BW-1:0] weight(input int mode, input int i, input int j);
    if (mode == 0) return BW'(j << FRAC);
    return BW'((((i * 73 + j * 29 + i * j * 7) % 1024) - 512) * 97);
  endfunction

  // Weight RAM: registers the addressed column on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NROW; i++) begin
      weightRow[i*BW +: BW] <= weight(ram_mode, i, int'(weightAddress));
    end
  end

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every dataReady pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (dataReady) begin
      ready_pulses++;
      prev_ready_cyc = last_ready_cyc;
      last_ready_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: dataReady at cycle %0d with no result pending", cyc);
      end else begin
        check("dot_output", dotOutput, exp_q.pop_front());
      end
    end
  end

  function automatic logic [VW-1:0] vec_one(input int idx, input int val);
    logic [VW-1:0] v;
    v = '0;
    v[idx*BW +: BW] = BW'(val);
    return v;
  endfunction

  function automatic logic [VW-1:0] vec_all(input int val);
    logic [VW-1:0] v;
    for (int j = 0; j < NCOL; j++) v[j*BW +: BW] = BW'(val);
    return v;
  endfunction

  function automatic logic [VW-1:0] vec_rand();
    logic [VW-1:0] v;
    for (int j = 0; j < NCOL; j++) v[j*BW +: BW] = BW'($urandom_range(0, (1 << BW) - 1));
    return v;
  endfunction

  function automatic logic [OW-1:0] splat(input int val);
    logic [OW-1:0] r;
    for (int i = 0; i < NROW; i++) r[i*BW +: BW] = BW'(val);
    return r;
  endfunction

  // Reference: exact integer dot products, floor shift, then clamp or wrap.
  function automatic logic [OW-1:0] model(input logic [VW-1:0] v, input int mode);
    logic [OW-1:0]       res;
    logic signed [BW-1:0] e;
    longint              s;
    longint              r;
    for (int i = 0; i < NROW; i++) begin
      s = 0;
      for (int j = 0; j < NCOL; j++) begin
        e = v[j*BW +: BW];
        s += longint'(weight(mode, i, j)) * longint'(e);
      end
      r = s >>> FRAC;
`ifdef ACC_SATURATE_EN
      if (r > RMAX) r = RMAX;
      else if (r < RMIN) r = RMIN;
`endif
      res[i*BW +: BW] = r[BW-1:0];
    end
    return res;
  endfunction

  // One product: pulse start, optionally check address/busy sequence, extra
  // ignored starts, vecInput scrambling, output hold and single-cycle ready.
  task automatic do_run(input logic [VW-1:0] v, input logic [OW-1:0] exp,
                        input bit check_seq, input bit pulse_extra, input bit scramble);
    bit  seen;
    int  exp_addr;
    @(negedge clk);
    vecInput = v;
    start    = 1'b1;
    exp_q.push_back(exp);
    runs_expected++;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (check_seq) begin
      check("busy_after_start", busy, 1);
      check("addr_k0", weightAddress, 0);
    end
    seen = 1'b0;
    for (int k = 1; k <= NCOL + 6 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (scramble) vecInput = vec_rand();
      start = pulse_extra && (k == 3 || k == 10);
      if (k == 5) check("dot_hold", dotOutput, last_exp);
      if (check_seq) begin
        exp_addr = (k < NCOL) ? k : ((k == NCOL) ? NCOL - 1 : 0);
        check($sformatf("addr_k%0d", k), weightAddress, exp_addr);
        if (k == NCOL) check("busy_in_wrap", busy, 1);
      end
      if (dataReady) begin
        seen = 1'b1;
        check("latency", k, NCOL + 1);
        check("busy_at_ready", busy, 0);
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: no dataReady within %0d cycles", NCOL + 6);
    end
    @(posedge clk);
    #1;
    check("ready_one_cycle", dataReady, 0);
    last_exp = exp;
  endtask

  initial begin
    logic [OW-1:0] exp;
    logic [OW-1:0] exp2;
    logic [VW-1:0] v2;
    int            base;

    tbl[0] = '{vec_one(3, 2048),   0, 1'b1, 6144};
    tbl[1] = '{vec_one(5, -2048),  0, 1'b1, -10240};
    tbl[2] = '{vec_all(1024),      0, 1'b1, 122880};
`ifdef ACC_SATURATE_EN
    tbl[3] = '{vec_all(2048),      0, 1'b1, 131071};
    tbl[4] = '{vec_all(-2048),     0, 1'b1, -131072};
`else
    tbl[3] = '{vec_all(2048),      0, 1'b1, -16384};
    tbl[4] = '{vec_all(-2048),     0, 1'b1, 16384};
`endif
    tbl[5] = '{vec_all(-131072),   1, 1'b0, 0};
    tbl[6] = '{vec_rand(),         1, 1'b0, 0};
    tbl[7] = '{vec_rand(),         1, 1'b0, 0};
    tbl[8] = '{vec_rand(),         1, 1'b0, 0};
    tbl[9] = '{vec_one(15, 77),    1, 1'b0, 0};

    // Reset state
    #3 reset = 1'b0;
    #10;
    check("reset_busy", busy, 0);
    check("reset_ready", dataReady, 0);
    check("reset_dot", dotOutput, '0);
    check("reset_addr", weightAddress, 0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven runs
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      ram_mode = tbl[t].mode;
      exp = tbl[t].use_const ? splat(tbl[t].row_val) : model(tbl[t].vec, tbl[t].mode);
      do_run(tbl[t].vec, exp, t == 0, 1'b0, t == 1 || t == 6);
    end

    // Starts during a run are ignored and not queued
    @(negedge clk);
    ram_mode = 0;
    base = ready_pulses;
    do_run(vec_one(3, 2048), splat(6144), 1'b0, 1'b1, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    check("ignored_starts_one_ready", ready_pulses - base, 1);

    // start held high: back-to-back runs every NCOL+2 cycles
    @(negedge clk);
    ram_mode = 1;
    v2 = vec_rand();
    exp  = model(tbl[7].vec, 1);
    exp2 = model(v2, 1);
    vecInput = tbl[7].vec;
    start = 1'b1;
    exp_q.push_back(exp);
    exp_q.push_back(exp2);
    runs_expected += 2;
    base = ready_pulses;
    @(posedge clk);
    #1;
    vecInput = v2;
    for (int k = 0; k < 40 && ready_pulses == base; k++) @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 40 && ready_pulses < base + 2; k++) @(negedge clk);
    check("b2b_ready_count", ready_pulses - base, 2);
    check("b2b_period", last_ready_cyc - prev_ready_cyc, NCOL + 2);
    last_exp = exp2;

    // Reset in the middle of RUN aborts at once with no ready pulse
    @(negedge clk);
    ram_mode = 0;
    vecInput = vec_one(3, 2048);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    base = ready_pulses;
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", dataReady, 0);
    check("abort_dot", dotOutput, '0);
    check("abort_addr", weightAddress, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (NCOL + 4) @(posedge clk);
    #1;
    check("abort_no_ready", ready_pulses - base, 0);
    last_exp = '0;
    do_run(vec_one(3, 2048), splat(6144), 1'b1, 1'b0, 1'b0);

    // Everything expected arrived, nothing extra
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("total_ready_pulses", ready_pulses, runs_expected);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
